// File: rtl/cali_err_gen_pkg.sv
// Shared types and sizing constants for the DTC calibration error generator.
package cali_err_gen_pkg;

  // Window controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Depth of the x delay line; covers every PD latency selectable by SYNC_DLY.
  localparam int DLY_DEPTH = 8;

  // Signed accumulator width: holds +/-128 for the longest window.
  localparam int ACC_W = 9;

  // Width of the dropped-sample counter and of the window sample count.
  localparam int DROP_W = 8;
  localparam int CNT_W  = 8;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

endpackage

// File: rtl/cali_err_sat.sv
// Left-shifts the signed window accumulator by the error gain and clamps the
// result into the signed EW-bit output range.
module cali_err_sat
  import cali_err_gen_pkg::*;
#(
  parameter int EW = 16
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [3:0]       i_shift,
  output logic [EW-1:0]    o_err
);

  // Wide enough that a 15-bit shift of the accumulator never overflows and
  // the EW-bit limits are always representable.
  localparam int SW = ACC_W + 16 + EW;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-EW+1){1'b0}}, {(EW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-EW+1){1'b1}}, {(EW-1){1'b0}}};

  logic signed [SW-1:0] w_ext;
  logic signed [SW-1:0] w_shl;

  assign w_ext = {{(SW-ACC_W){i_acc[ACC_W-1]}}, i_acc};
  assign w_shl = w_ext <<< i_shift;

  // Clamp the shifted value to the signed output range.
  always_comb begin
    if (w_shl > SAT_MAX) begin
      o_err = SAT_MAX[EW-1:0];
    end else if (w_shl < SAT_MIN) begin
      o_err = SAT_MIN[EW-1:0];
    end else begin
      o_err = w_shl[EW-1:0];
    end
  end

endmodule

// File: rtl/cali_err_gen.sv
// DTC calibration error generator: aligns the issued control word with the
// delayed bang-bang PD decision, averages PD results over a window confined
// to one x segment, and presents the scaled error through a valid/ready port.
module cali_err_gen
  import cali_err_gen_pkg::*;
#(
  parameter int XW = 12,
  parameter int EW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [XW-1:0] i_x,
  input  logic          i_pd_in,
  input  logic          i_pd_vld,
  input  logic [2:0]    i_sync_dly,
  input  logic [1:0]    i_psegs,
  input  logic [2:0]    i_avg_log2,
  input  logic [3:0]    i_kerr,
  output logic [EW-1:0] o_err,
  output logic [XW-1:0] o_err_x,
  output logic [2:0]    o_err_seg,
  output logic [7:0]    o_err_cnt,
  output logic          o_err_vld,
  input  logic          i_err_rdy,
  output logic [7:0]    o_drop_cnt
);

  state_e r_state;
  state_e w_state_nxt;

  logic [XW-1:0]           r_xdl [DLY_DEPTH];
  logic [2:0]              r_sync_dly;
  logic [1:0]              r_psegs;
  logic [2:0]              r_avg_log2;
  logic [3:0]              r_kerr;
  logic [3:0]              r_fill_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic [2:0]              r_win_seg;
  logic [EW-1:0]           r_err;
  logic [XW-1:0]           r_err_x;
  logic [2:0]              r_err_seg;
  logic [CNT_W-1:0]        r_err_cnt;
  logic [DROP_W-1:0]       r_drop_cnt;

  logic [XW-1:0]           w_x_al;
  logic [2:0]              w_seg;
  logic [CNT_W-1:0]        w_cnt_lim;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic [CNT_W-1:0]        w_cnt_fin;
  logic signed [ACC_W-1:0] w_acc_inc;
  logic signed [ACC_W-1:0] w_acc_fin;
  logic [EW-1:0]           w_err_sat;
  logic                    w_fill_ld;
  logic                    w_accept;
  logic                    w_close;
  logic                    w_drop;
  logic                    w_hs;

  // x that was issued when the PD sample now arriving was launched.
  assign w_x_al    = r_xdl[r_sync_dly];
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_cnt_lim = CNT_W'(1) << r_avg_log2;
  assign w_acc_inc = i_pd_in ? (r_acc + ACC_W'(1)) : (r_acc - ACC_W'(1));
  // Values the window closes with: a segment-mismatch close leaves them as is.
  assign w_acc_fin = w_accept ? w_acc_inc : r_acc;
  assign w_cnt_fin = w_accept ? w_cnt_inc : r_cnt;

  // Segment index from the top PSEGS bits of the aligned x.
  always_comb begin
    w_seg = 3'd0;
    case (r_psegs)
      2'd1:    w_seg = {2'b00, w_x_al[XW-1]};
      2'd2:    w_seg = {1'b0, w_x_al[XW-1:XW-2]};
      2'd3:    w_seg = w_x_al[XW-1:XW-3];
      default: w_seg = 3'd0;
    endcase
  end

  // Advance the window controller state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control strobes.
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_ld   = 1'b0;
    w_accept    = 1'b0;
    w_close     = 1'b0;
    w_drop      = 1'b0;
    w_hs        = 1'b0;
    if (!i_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_FILL;
          w_fill_ld   = 1'b1;
        end
        ST_FILL: begin
          if (r_fill_cnt == 4'd0) begin
            w_state_nxt = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (i_pd_vld) begin
            if ((r_cnt != '0) && (w_seg != r_win_seg)) begin
              w_close     = 1'b1;
              w_drop      = 1'b1;
              w_state_nxt = ST_HOLD;
            end else begin
              w_accept = 1'b1;
              if (w_cnt_inc == w_cnt_lim) begin
                w_close     = 1'b1;
                w_state_nxt = ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          w_drop = i_pd_vld;
          if (i_err_rdy) begin
            w_hs        = 1'b1;
            w_state_nxt = ST_ACCUM;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Shift the issued x through the alignment delay line every cycle.
  // NOTE: the delay line is a handful of flops, so it is cleared on reset to
  // make the aligned x deterministic right after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DLY_DEPTH; i++) begin
        r_xdl[i] <= '0;
      end
    end else begin
      r_xdl[0] <= i_x;
      for (int i = 1; i < DLY_DEPTH; i++) begin
        r_xdl[i] <= r_xdl[i-1];
      end
    end
  end

  // Capture configuration on entry to FILL and run the fill countdown.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync_dly <= '0;
      r_psegs    <= '0;
      r_avg_log2 <= '0;
      r_kerr     <= '0;
      r_fill_cnt <= '0;
    end else if (w_fill_ld) begin
      r_sync_dly <= i_sync_dly;
      r_psegs    <= i_psegs;
      r_avg_log2 <= i_avg_log2;
      r_kerr     <= i_kerr;
      r_fill_cnt <= {1'b0, i_sync_dly} + 4'd1;
    end else if ((r_state == ST_FILL) && (r_fill_cnt != 4'd0)) begin
      r_fill_cnt <= r_fill_cnt - 4'd1;
    end
  end

  // Window accumulator, sample count and window segment.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_win_seg <= '0;
    end else if (w_accept) begin
      r_acc <= w_acc_inc;
      r_cnt <= w_cnt_inc;
      if (r_cnt == '0) begin
        r_win_seg <= w_seg;
      end
    end else if (w_hs) begin
      r_acc <= '0;
      r_cnt <= '0;
    end
  end

  // Output registers: x/segment track accepted samples, error/count load on close.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_err     <= '0;
      r_err_x   <= '0;
      r_err_seg <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_err_x   <= w_x_al;
        r_err_seg <= w_seg;
      end
      if (w_close) begin
        r_err     <= w_err_sat;
        r_err_cnt <= w_cnt_fin;
      end
    end
  end

  // Saturating count of PD samples that could not be used.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != DROP_MAX)) begin
      r_drop_cnt <= r_drop_cnt + DROP_W'(1);
    end
  end

  cali_err_sat #(
    .EW(EW)
  ) u_sat (
    .i_acc   (w_acc_fin),
    .i_shift (r_kerr),
    .o_err   (w_err_sat)
  );

  assign o_err      = r_err;
  assign o_err_x    = r_err_x;
  assign o_err_seg  = r_err_seg;
  assign o_err_cnt  = r_err_cnt;
  assign o_err_vld  = (r_state == ST_HOLD);
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_cali_err_gen.sv
// Self-checking bench for cali_err_gen: table of window vectors with a
// scoreboard on the output handshake, plus hand sequences for alignment,
// segment close, HOLD drops, and EN/reset aborts.
module tb_cali_err_gen;

  localparam int XW = 12;
  localparam int EW = 16;
  localparam logic [XW-1:0] XC = 12'h123;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [XW-1:0] x;
  logic          pd_in;
  logic          pd_vld;
  logic [2:0]    sync_dly;
  logic [1:0]    psegs;
  logic [2:0]    avg_log2;
  logic [3:0]    kerr;
  logic          err_rdy;
  logic [EW-1:0] o_err;
  logic [XW-1:0] o_err_x;
  logic [2:0]    o_err_seg;
  logic [7:0]    o_err_cnt;
  logic          o_err_vld;
  logic [7:0]    o_drop_cnt;

  cali_err_gen #(.XW(XW), .EW(EW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_x        (x),
    .i_pd_in    (pd_in),
    .i_pd_vld   (pd_vld),
    .i_sync_dly (sync_dly),
    .i_psegs    (psegs),
    .i_avg_log2 (avg_log2),
    .i_kerr     (kerr),
    .o_err      (o_err),
    .o_err_x    (o_err_x),
    .o_err_seg  (o_err_seg),
    .o_err_cnt  (o_err_cnt),
    .o_err_vld  (o_err_vld),
    .i_err_rdy  (err_rdy),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard of expected window results, in close order.
  typedef struct {
    longint err;
    int     cnt;
    int     seg;
    int     xv;
  } exp_t;
  exp_t sb_q[$];

  task automatic push_exp(input longint e, input int c, input int s, input int xv);
    exp_t t;
    t.err = e; t.cnt = c; t.seg = s; t.xv = xv;
    sb_q.push_back(t);
  endtask

  // Pop one expectation on every rising ERR_VLD and compare the held outputs.
  logic vld_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (o_err_vld && !vld_prev) begin
      if (sb_q.size() == 0) begin
        check("unexpected_vld", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_err", $signed(o_err), e.err);
        check("sb_cnt", o_err_cnt, e.cnt);
        check("sb_seg", o_err_seg, e.seg);
        check("sb_x", o_err_x, e.xv);
      end
    end
    vld_prev <= o_err_vld;
  end

  // Window vectors: configuration, PD pattern (bit s = sample s), expected result.
  typedef struct {
    logic [2:0]   sd;
    logic [1:0]   ps;
    logic [2:0]   av;
    logic [3:0]   k;
    logic [127:0] pat;
    longint       exp_err;
    int           exp_cnt;
  } vec_t;
  localparam int NV = 11;
  vec_t tbl [NV];

  function automatic logic [XW-1:0] ramp(input int k);
    return XW'(200 + 3 * k);
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; pd_vld = 1'b0; err_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_window(input logic [2:0] sd, input logic [1:0] ps,
                              input logic [2:0] av, input logic [3:0] k);
    @(negedge clk);
    en = 1'b0; pd_vld = 1'b0; err_rdy = 1'b0;
    @(negedge clk);
    sync_dly = sd; psegs = ps; avg_log2 = av; kerr = k; en = 1'b1;
    @(negedge clk);
    // Configuration changes while enabled must be ignored.
    sync_dly = 3'($urandom); psegs = 2'($urandom);
    avg_log2 = 3'($urandom); kerr = 4'($urandom);
    repeat (12) @(negedge clk);
  endtask

  task automatic send_sample(input logic pd);
    @(negedge clk);
    pd_vld = 1'b1; pd_in = pd;
    @(negedge clk);
    pd_vld = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk);
    err_rdy = 1'b1;
    @(negedge clk);
    err_rdy = 1'b0;
    check("vld_after_hs", o_err_vld, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic vld_d;

    tbl[0]  = '{3'd3, 2'd0, 3'd2, 4'd4,  128'hF,      64,     4};
    tbl[1]  = '{3'd0, 2'd0, 3'd2, 4'd0,  128'hD,      2,      4};
    tbl[2]  = '{3'd7, 2'd0, 3'd1, 4'd3,  128'h1,      0,      2};
    tbl[3]  = '{3'd1, 2'd0, 3'd7, 4'd15, {128{1'b1}}, 32767,  128};
    tbl[4]  = '{3'd2, 2'd0, 3'd7, 4'd15, 128'h0,      -32768, 128};
    tbl[5]  = '{3'd4, 2'd0, 3'd0, 4'd2,  128'h0,      -4,     1};
    tbl[6]  = '{3'd6, 2'd0, 3'd3, 4'd1,  128'h0,      -16,    8};
    tbl[7]  = '{3'd5, 2'd0, 3'd3, 4'd10, 128'hFF,     8192,   8};
    tbl[8]  = '{3'd0, 2'd0, 3'd5, 4'd11, {128{1'b1}}, 32767,  32};
    tbl[9]  = '{3'd0, 2'd0, 3'd4, 4'd11, 128'h0,      -32768, 16};
    tbl[10] = '{3'd3, 2'd0, 3'd4, 4'd11, 128'hFFFF,   32767,  16};

    rst = 1'b1; en = 1'b0; x = XC; pd_in = 1'b0; pd_vld = 1'b0;
    sync_dly = '0; psegs = '0; avg_log2 = '0; kerr = '0; err_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_err", o_err, 0);
    check("rst_err_x", o_err_x, 0);
    check("rst_err_seg", o_err_seg, 0);
    check("rst_err_cnt", o_err_cnt, 0);
    check("rst_vld", o_err_vld, 0);
    check("rst_drop", o_drop_cnt, 0);

    // Table-driven windows.
    for (int i = 0; i < NV; i++) begin
      start_window(tbl[i].sd, tbl[i].ps, tbl[i].av, tbl[i].k);
      n = 1 << tbl[i].av;
      for (int s = 0; s < n; s++) begin
        if (s == n - 1) begin
          check($sformatf("pre_close_vld_%0d", i), o_err_vld, 0);
          push_exp(tbl[i].exp_err, tbl[i].exp_cnt, 0, int'(XC));
        end
        send_sample(tbl[i].pat[s]);
      end
      check($sformatf("close_vld_%0d", i), o_err_vld, 1);
      handshake();
    end

    // Alignment: ERR_X must be the x issued 6 cycles before each sample.
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    sync_dly = 3'd5; psegs = 2'd0; avg_log2 = 3'd7; kerr = 4'd0; en = 1'b1;
    vld_d = 1'b0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (vld_d) check("ramp_err_x", o_err_x, ramp(k - 7));
      x      = ramp(k);
      pd_in  = 1'b1;
      pd_vld = (k >= 16) && (k % 4 == 0);
      vld_d  = pd_vld;
    end
    @(negedge clk);
    pd_vld = 1'b0; x = XC;

    // Segment mismatch closes the window without accepting the sample.
    reset_dut();
    @(negedge clk);
    sync_dly = 3'd0; psegs = 2'd3; avg_log2 = 3'd3; kerr = 4'd0; en = 1'b1;
    x = 12'd410;
    repeat (8) @(negedge clk);
    send_sample(1'b1);
    check("seg_first_x", o_err_x, 410);
    x = 12'd450;
    send_sample(1'b0);
    x = 12'd1229;
    push_exp(0, 2, 0, 450);
    send_sample(1'b1);
    check("seg_close_vld", o_err_vld, 1);
    check("seg_drop", o_drop_cnt, 1);
    handshake();
    send_sample(1'b1);
    check("seg_new_window", o_err_seg, 2);
    check("seg_drop_kept", o_drop_cnt, 1);

    // HOLD: outputs stable with ERR_RDY low, every PD sample dropped.
    reset_dut();
    x = XC;
    start_window(3'd0, 2'd0, 3'd1, 4'd0);
    send_sample(1'b1);
    push_exp(2, 2, 0, int'(XC));
    send_sample(1'b1);
    check("hold_enter_vld", o_err_vld, 1);
    pd_vld = 1'b1; pd_in = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_stable", {o_err_vld, o_err, o_err_cnt, o_err_x},
            {1'b1, 16'd2, 8'd2, XC});
    end
    check("hold_drop_10", o_drop_cnt, 10);
    err_rdy = 1'b1;
    @(negedge clk);
    err_rdy = 1'b0; pd_vld = 1'b0;
    check("hold_hs_vld", o_err_vld, 0);
    check("hold_drop_11", o_drop_cnt, 11);

    // Drop counter saturation.
    send_sample(1'b1);
    push_exp(2, 2, 0, int'(XC));
    send_sample(1'b1);
    pd_vld = 1'b1;
    repeat (244) @(negedge clk);
    check("drop_at_255", o_drop_cnt, 255);
    repeat (20) @(negedge clk);
    pd_vld = 1'b0;
    check("drop_sat", o_drop_cnt, 255);
    handshake();

    // EN dropped mid-window discards the partial window.
    start_window(3'd2, 2'd0, 3'd2, 4'd5);
    send_sample(1'b1);
    send_sample(1'b1);
    check("abort_x_before", o_err_x, XC);
    en = 1'b0;
    @(negedge clk);
    check("abort_vld", o_err_vld, 0);
    check("abort_err_x", o_err_x, 0);
    check("abort_err_cnt", o_err_cnt, 0);
    sync_dly = 3'd2; psegs = 2'd0; avg_log2 = 3'd2; kerr = 4'd5; en = 1'b1;
    repeat (12) @(negedge clk);
    send_sample(1'b0);
    send_sample(1'b0);
    check("abort_no_early_vld", o_err_vld, 0);
    send_sample(1'b0);
    push_exp(-128, 4, 0, int'(XC));
    send_sample(1'b0);
    check("abort_new_close", o_err_vld, 1);
    handshake();

    // Reset pulsed mid-window discards everything, including DROP_CNT.
    send_sample(1'b1);
    send_sample(1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_drop", o_drop_cnt, 0);
    check("rst_mid_err", o_err, 0);
    check("rst_mid_vld", o_err_vld, 0);
    repeat (12) @(negedge clk);
    send_sample(1'b1);
    send_sample(1'b1);
    check("rst_no_early_vld", o_err_vld, 0);
    send_sample(1'b1);
    push_exp(128, 4, 0, int'(XC));
    send_sample(1'b1);
    check("rst_new_close", o_err_vld, 1);
    handshake();

    repeat (2) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
